alu_seq: RTL and testbench

Parametrised, registered successor to the 4-bit combinational ALU.
- Operands are W bits wide; the result is 2W bits; status flags are added.
- Upstream and downstream use valid/ready handshakes.
- Multiplication is a multi-cycle shift-add operation; every other op has 1-cycle latency.
- Sits between an operand source (register file / test sequencer) and a result consumer that may stall.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_mul_seq.sv | 74 +++++++
 rtl/alu_seq.sv | 156 +++++++++++++++
 tb/tb_alu_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and width helpers for the registered sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_e;

  localparam int unsigned W_DEFAULT = 4;

  function automatic int unsigned res_width(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned sh_width(input int unsigned w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// W-cycle shift-add multiplier; done and p are valid in the cycle of the final step.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             done,
  output logic [2*W-1:0]   p
);

  localparam int unsigned CW = sh_width(W);

  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic [2*W-1:0] addend;
  logic [2*W-1:0] acc_step;
  logic           last;

  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    acc_step = acc_q + addend;
    last     = busy_q && (cnt_q == CW'(W - 1));
    done     = last;
    // Product is taken from the step result so the last step and the load share one edge.
    p        = acc_step;

    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;

    if (start) begin
      acc_d    = '0;
      mcand_d  = {{W{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered W-bit ALU with valid/ready handshakes, 2W-bit result and status flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   y,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned SW = sh_width(W);
  localparam int unsigned RW = res_width(W);

  state_e         state_q, state_d;
  logic [RW-1:0]  y_q, y_d;
  logic           z_q, z_d;
  logic           c_q, c_d;
  logic           v_q, v_d;
  logic           init_q;

  op_e            op;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [RW-1:0]  shl;
  logic [RW-1:0]  res;
  logic           res_c;
  logic           res_v;
  logic           accept;
  logic           mul_start;
  logic           mul_done;
  logic [RW-1:0]  mul_p;

  alu_mul_seq #(.W(W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_comb begin
    op    = op_e'(s);
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    shl   = {{W{1'b0}}, a} << b[SW-1:0];
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      OP_ADD: begin
        res   = {{(W-1){1'b0}}, sum};
        res_c = sum[W];
        res_v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        res   = {{(W-1){1'b0}}, diff};
        res_c = diff[W];
        res_v = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_AND:  res = {{W{1'b0}}, a & b};
      OP_OR:   res = {{W{1'b0}}, a | b};
      OP_XOR:  res = {{W{1'b0}}, a ^ b};
      OP_SHL:  res = shl;
      OP_CMP:  res = {{(RW-2){1'b0}}, (a > b), (a == b)};
      default: res = '0;
    endcase
  end

  // init_q keeps in_ready low until the first edge after reset release.
  always_comb begin
    in_ready  = init_q && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    out_valid = (state_q == DONE);
    accept    = in_valid && in_ready;
  end

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    z_d       = z_q;
    c_d       = c_q;
    v_d       = v_q;
    mul_start = 1'b0;

    case (state_q)
      IDLE: ;
      MUL: begin
        if (mul_done) begin
          y_d     = mul_p;
          z_d     = (mul_p == '0);
          c_d     = 1'b0;
          v_d     = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready && !in_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // accept is only possible in IDLE or while DONE retires, so it overrides the above.
    if (accept) begin
      if (op == OP_MUL) begin
        mul_start = 1'b1;
        state_d   = MUL;
      end else begin
        y_d     = res;
        z_d     = (res == '0);
        c_d     = res_c;
        v_d     = res_v;
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    y      = y_q;
    flag_z = z_q;
    flag_c = c_q;
    flag_v = v_q;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at W=4: directed latency/backpressure/reset checks plus random ops.
module tb_alu_seq;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2:0]     s;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] y;
  logic           flag_z;
  logic           flag_c;
  logic           flag_v;

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       c;
    logic       v;
  } res_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;
  res_t exp_q[$];
  res_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input int ia, input int ib, input int op);
    int   full;
    int   half;
    int   sa;
    int   sb;
    int   sr;
    int   r;
    res_t e;
    full = 1 << W;
    half = 1 << (W - 1);
    sa   = (ia >= half) ? ia - full : ia;
    sb   = (ib >= half) ? ib - full : ib;
    e    = '0;
    r    = 0;
    case (op)
      0: begin
        r   = ia + ib;
        e.c = (r >= full);
        sr  = sa + sb;
        e.v = (sr >= half) || (sr < -half);
      end
      1: begin
        r   = ((ia - ib) & (full - 1)) | ((ia < ib) ? full : 0);
        e.c = (ia < ib);
        sr  = sa - sb;
        e.v = (sr >= half) || (sr < -half);
      end
      2: r = ia * ib;
      3: r = ia & ib;
      4: r = ia | ib;
      5: r = ia ^ ib;
      6: r = ia << (ib % W);
      default: r = ((ia > ib) ? 2 : 0) + ((ia == ib) ? 1 : 0);
    endcase
    e.y = r[7:0];
    e.z = (e.y == 8'h00);
    return e;
  endfunction

  // Drive one op and wait for acceptance; returns the number of edges waited.
  task automatic send(input int ia, input int ib, input int op, output int edges);
    bit r;
    int guard;
    a        = ia[W-1:0];
    b        = ib[W-1:0];
    s        = op[2:0];
    in_valid = 1'b1;
    exp_q.push_back(model(ia, ib, op));
    r     = 1'b0;
    guard = 0;
    while (!r && guard < 50) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      guard++;
      if (!r) begin
        #1;
        out_ready = 1'b1;
      end
    end
    if (!r) check("accept_timeout", 0, 1);
    edges = guard;
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res", 32'({y, flag_z, flag_c, flag_v}), 32'(mon_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    s         = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_y", 32'(y), 0);
    check("rst_flags", 32'({flag_z, flag_c, flag_v}), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    #1;
    check("ready_pre", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    check("ready_post", 32'(in_ready), 1);
    out_ready = 1'b1;

    send(9, 3, 0, cyc);
    check("add_valid", 32'(out_valid), 1);
    check("add_y", 32'(y), 32'h0C);
    check("add_c", 32'(flag_c), 0);
    @(posedge clk); #1;

    send(9, 11, 1, cyc);
    check("sub_y", 32'(y), 32'h1E);
    check("sub_c", 32'(flag_c), 1);
    @(posedge clk); #1;

    send(13, 11, 2, cyc);
    check("mul_ready0", 32'(in_ready), 0);
    check("mul_valid0", 32'(out_valid), 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("mul_ready", 32'(in_ready), 0);
      check("mul_valid", 32'(out_valid), 0);
    end
    @(posedge clk); #1;
    check("mul_done", 32'(out_valid), 1);
    check("mul_y", 32'(y), 32'h8F);
    @(posedge clk); #1;

    send(0, 15, 2, cyc);
    repeat (4) @(posedge clk);
    #1;
    check("mul0_valid", 32'(out_valid), 1);
    check("mul0_y", 32'(y), 0);
    check("mul0_z", 32'(flag_z), 1);
    @(posedge clk); #1;

    send(11, 7, 6, cyc);
    check("shl_y", 32'(y), 32'h58);
    @(posedge clk); #1;
    send(5, 11, 7, cyc);
    check("cmp_lt", 32'(y), 0);
    @(posedge clk); #1;
    send(11, 11, 7, cyc);
    check("cmp_eq", 32'(y), 1);
    @(posedge clk); #1;

    out_ready = 1'b0;
    send(10, 11, 5, cyc);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid), 1);
      check("bp_y", 32'(y), 32'h01);
    end
    out_ready = 1'b1;
    send(14, 7, 3, cyc);
    check("b2b_edges", 32'(cyc), 1);
    check("b2b_valid", 32'(out_valid), 1);
    check("b2b_y", 32'(y), 32'h06);
    @(posedge clk); #1;

    send(7, 9, 2, cyc);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_y", 32'(y), 0);
    check("midrst_ready", 32'(in_ready), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(3, 5, 2, cyc);
    repeat (4) @(posedge clk);
    #1;
    check("postrst_valid", 32'(out_valid), 1);
    check("postrst_y", 32'(y), 32'h0F);

    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 7)), cyc);
    end

    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    check("drain", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
